// File: rtl/dmem_ctrl.sv
// Byte-addressed RV32 data memory with valid/ready request/response handshake,
// registered one-cycle reads and a post-reset clear sweep. Optional macro: DMEM_MISALIGN_TRAP_EN.
module dmem_ctrl #(
    parameter int DEPTH = 256,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [2:0]    req_funct3,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err,
    output logic          init_done
);

    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {INIT, IDLE, RESP} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] cnt_q, cnt_d;
    logic          init_done_q, init_done_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d;

    logic [31:0]   mem [DEPTH];
    logic          mem_we;
    logic [IW-1:0] mem_widx;
    logic [31:0]   mem_wdata;

    logic [IW-1:0] word_idx;
    logic [1:0]    lane;
    logic [31:0]   rd_word;
    logic [31:0]   byte_shift;
    logic [15:0]   half_sel;
    logic [AW-1:0] addr_hi;
    logic          range_err, f3_err, misalign, req_err;
    logic [31:0]   load_data, store_data, lane_mask, lane_data;
    logic          accept;

    assign req_ready = (state_q == IDLE) | ((state_q == RESP) & rsp_ready);
    assign accept    = req_valid & req_ready;
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign init_done = init_done_q;

    // Request decode: error classification plus load extraction and store merge
    always_comb begin
        word_idx   = req_addr[IW+1:2];
        lane       = req_addr[1:0];
        rd_word    = mem[word_idx];
        byte_shift = rd_word >> {lane, 3'b000};
        half_sel   = lane[1] ? rd_word[31:16] : rd_word[15:0];
        addr_hi    = req_addr >> (IW + 2);
        range_err  = |addr_hi;
        if (req_write) f3_err = (req_funct3 > 3'b010);
        else           f3_err = (req_funct3 == 3'b011) | (req_funct3[2:1] == 2'b11);
`ifdef DMEM_MISALIGN_TRAP_EN
        misalign = ((req_funct3[1:0] == 2'b01) & lane[0]) |
                   ((req_funct3 == 3'b010) & (lane != 2'b00));
`else
        misalign = 1'b0;
`endif
        req_err = range_err | f3_err | misalign;

        case (req_funct3)
            3'b000:  load_data = {{24{byte_shift[7]}}, byte_shift[7:0]};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b010:  load_data = rd_word;
            3'b100:  load_data = {24'h0, byte_shift[7:0]};
            3'b101:  load_data = {16'h0, half_sel};
            default: load_data = 32'h0;
        endcase

        case (req_funct3)
            3'b000: begin
                lane_mask = 32'h0000_00FF << {lane, 3'b000};
                lane_data = {4{req_wdata[7:0]}};
            end
            3'b001: begin
                lane_mask = lane[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
                lane_data = {2{req_wdata[15:0]}};
            end
            default: begin
                lane_mask = 32'hFFFF_FFFF;
                lane_data = req_wdata;
            end
        endcase
        store_data = (rd_word & ~lane_mask) | (lane_data & lane_mask);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        mem_we      = 1'b0;
        mem_widx    = cnt_q;
        mem_wdata   = 32'h0;
        case (state_q)
            INIT: begin
                mem_we = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == IW'(DEPTH - 1)) begin
                    state_d     = IDLE;
                    init_done_d = 1'b1;
                    cnt_d       = '0;
                end
            end
            IDLE, RESP: begin
                if (accept) begin
                    state_d     = RESP;
                    rsp_err_d   = req_err;
                    rsp_rdata_d = (req_err | req_write) ? 32'h0 : load_data;
                    if (req_write & ~req_err) begin
                        mem_we    = 1'b1;
                        mem_widx  = word_idx;
                        mem_wdata = store_data;
                    end
                end else if ((state_q == RESP) & rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= INIT;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Storage is not reset; the INIT sweep clears it after every reset instead
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_widx] <= mem_wdata;
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl (DEPTH=256, AW=32).
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready, req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err, init_done;
    logic [31:0] rsp_rdata;

    int tests = 0;
    int fails = 0;

    dmem_ctrl #(.DEPTH(256), .AW(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .init_done(init_done)
    );

    always #5 clk = ~clk;

    // One complete transaction; an unaccepted request yields X results so callers' checks fail
    task automatic xact(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic v, output logic [31:0] rd,
                        output logic er);
        int n = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
        rsp_ready = 1'b0;
        #1;
        while (!req_ready && n < 20) begin
            @(negedge clk); #1; n++;
        end
        if (!req_ready) begin
            req_valid = 1'b0;
            v = 1'bx; rd = 'x; er = 1'bx;
            return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        v = rsp_valid; rd = rsp_rdata; er = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic wait_init(output int cycles, output logic early_ready);
        cycles = 0; early_ready = 1'b0;
        while (!init_done && cycles < 400) begin
            @(negedge clk); cycles++;
            if (!init_done && req_ready) early_ready = 1'b1;
        end
    endtask

    task automatic test_reset();
        int cyc; logic early; logic v, er; logic [31:0] rd;
        reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b0;
        req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
        #22;
        tests++; if (req_ready !== 1'b0) begin fails++; $display("[TB] FAIL reset_req_ready: got %b expected 0", req_ready); end
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        tests++; if (rsp_rdata !== 32'h0) begin fails++; $display("[TB] FAIL reset_rsp_rdata: got %h expected 0", rsp_rdata); end
        tests++; if (rsp_err !== 1'b0) begin fails++; $display("[TB] FAIL reset_rsp_err: got %b expected 0", rsp_err); end
        tests++; if (init_done !== 1'b0) begin fails++; $display("[TB] FAIL reset_init_done: got %b expected 0", init_done); end
        @(negedge clk); reset_n = 1'b1;
        wait_init(cyc, early);
        tests++; if (cyc !== 256) begin fails++; $display("[TB] FAIL init_cycles: got %0d expected 256", cyc); end
        tests++; if (early !== 1'b0) begin fails++; $display("[TB] FAIL init_ready_early: got %b expected 0", early); end
        tests++; if (req_ready !== 1'b1) begin fails++; $display("[TB] FAIL idle_ready: got %b expected 1", req_ready); end
        xact(1'b0, 3'b010, 32'h3FC, 32'h0, v, rd, er);
        tests++; if ({v, er, rd} !== {1'b1, 1'b0, 32'h0}) begin fails++; $display("[TB] FAIL lw_3fc: got v=%b err=%b rdata=%h expected v=1 err=0 rdata=00000000", v, er, rd); end
    endtask

    task automatic test_word_store();
        logic v, er; logic [31:0] rd;
        xact(1'b1, 3'b010, 32'h10, 32'h12345678, v, rd, er);
        tests++; if ({v, er, rd} !== {1'b1, 1'b0, 32'h0}) begin fails++; $display("[TB] FAIL sw_10: got v=%b err=%b rdata=%h expected v=1 err=0 rdata=00000000", v, er, rd); end
        xact(1'b0, 3'b000, 32'h13, 32'h0, v, rd, er);
        tests++; if ({er, rd} !== {1'b0, 32'h00000012}) begin fails++; $display("[TB] FAIL lb_13: got err=%b rdata=%h expected err=0 rdata=00000012", er, rd); end
        xact(1'b0, 3'b001, 32'h12, 32'h0, v, rd, er);
        tests++; if ({er, rd} !== {1'b0, 32'h00001234}) begin fails++; $display("[TB] FAIL lh_12: got err=%b rdata=%h expected err=0 rdata=00001234", er, rd); end
        xact(1'b0, 3'b010, 32'h10, 32'h0, v, rd, er);
        tests++; if ({er, rd} !== {1'b0, 32'h12345678}) begin fails++; $display("[TB] FAIL lw_10: got err=%b rdata=%h expected err=0 rdata=12345678", er, rd); end
        xact(1'b0, 3'b001, 32'h10, 32'h0, v, rd, er);
        tests++; if ({er, rd} !== {1'b0, 32'h00005678}) begin fails++; $display("[TB] FAIL lh_10: got err=%b rdata=%h expected err=0 rdata=00005678", er, rd); end
    endtask

    task automatic test_byte_store();
        logic v, er; logic [31:0] rd;
        xact(1'b1, 3'b000, 32'h21, 32'hAAAAAA80, v, rd, er);
        tests++; if ({v, er} !== 2'b10) begin fails++; $display("[TB] FAIL sb_21: got v=%b err=%b expected v=1 err=0", v, er); end
        xact(1'b0, 3'b000, 32'h21, 32'h0, v, rd, er);
        tests++; if (rd !== 32'hFFFFFF80) begin fails++; $display("[TB] FAIL lb_21: got %h expected ffffff80", rd); end
        xact(1'b0, 3'b100, 32'h21, 32'h0, v, rd, er);
        tests++; if (rd !== 32'h00000080) begin fails++; $display("[TB] FAIL lbu_21: got %h expected 00000080", rd); end
        xact(1'b0, 3'b010, 32'h20, 32'h0, v, rd, er);
        tests++; if (rd !== 32'h00008000) begin fails++; $display("[TB] FAIL lw_20: got %h expected 00008000", rd); end
        xact(1'b1, 3'b001, 32'h26, 32'h5555C001, v, rd, er);
        xact(1'b0, 3'b001, 32'h26, 32'h0, v, rd, er);
        tests++; if (rd !== 32'hFFFFC001) begin fails++; $display("[TB] FAIL lh_26: got %h expected ffffc001", rd); end
        xact(1'b0, 3'b010, 32'h24, 32'h0, v, rd, er);
        tests++; if (rd !== 32'hC0010000) begin fails++; $display("[TB] FAIL lw_24: got %h expected c0010000", rd); end
    endtask

    task automatic test_back_to_back();
        logic v, er; logic [31:0] rd;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b001; req_addr = 32'h40;
        req_wdata = 32'h1234BEEF; rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_write = 1'b0; req_funct3 = 3'b101; req_addr = 32'h42; req_wdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++; if ({rsp_valid, rsp_err, rsp_rdata, req_ready} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
                fails++; $display("[TB] FAIL b2b_hold%0d: got v=%b err=%b rdata=%h ready=%b expected v=1 err=0 rdata=00000000 ready=0", i, rsp_valid, rsp_err, rsp_rdata, req_ready);
            end
        end
        rsp_ready = 1'b1; #1;
        tests++; if (req_ready !== 1'b1) begin fails++; $display("[TB] FAIL b2b_ready: got %b expected 1", req_ready); end
        @(posedge clk); #1;
        req_valid = 1'b0; rsp_ready = 1'b0;
        tests++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h0}) begin
            fails++; $display("[TB] FAIL b2b_lhu_42: got v=%b err=%b rdata=%h expected v=1 err=0 rdata=00000000", rsp_valid, rsp_err, rsp_rdata);
        end
        rsp_ready = 1'b1; @(posedge clk); #1; rsp_ready = 1'b0;
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("[TB] FAIL b2b_drain: got %b expected 0", rsp_valid); end
        xact(1'b0, 3'b101, 32'h40, 32'h0, v, rd, er);
        tests++; if ({er, rd} !== {1'b0, 32'h0000BEEF}) begin fails++; $display("[TB] FAIL lhu_40: got err=%b rdata=%h expected err=0 rdata=0000beef", er, rd); end
    endtask

    task automatic test_errors();
        logic v, er; logic [31:0] rd;
        xact(1'b0, 3'b010, 32'h400, 32'h0, v, rd, er);
        tests++; if ({er, rd} !== {1'b1, 32'h0}) begin fails++; $display("[TB] FAIL lw_range: got err=%b rdata=%h expected err=1 rdata=00000000", er, rd); end
        xact(1'b0, 3'b011, 32'h10, 32'h0, v, rd, er);
        tests++; if ({er, rd} !== {1'b1, 32'h0}) begin fails++; $display("[TB] FAIL load_f3_011: got err=%b rdata=%h expected err=1 rdata=00000000", er, rd); end
        xact(1'b0, 3'b110, 32'h10, 32'h0, v, rd, er);
        tests++; if (er !== 1'b1) begin fails++; $display("[TB] FAIL load_f3_110: got err=%b expected 1", er); end
        xact(1'b1, 3'b010, 32'h402, 32'hDEADDEAD, v, rd, er);
        tests++; if (er !== 1'b1) begin fails++; $display("[TB] FAIL sw_range: got err=%b expected 1", er); end
        xact(1'b1, 3'b011, 32'h10, 32'hFFFFFFFF, v, rd, er);
        tests++; if (er !== 1'b1) begin fails++; $display("[TB] FAIL store_f3_011: got err=%b expected 1", er); end
        xact(1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, v, rd, er);
        tests++; if (er !== 1'b1) begin fails++; $display("[TB] FAIL store_f3_100: got err=%b expected 1", er); end
        xact(1'b0, 3'b010, 32'h10, 32'h0, v, rd, er);
        tests++; if (rd !== 32'h12345678) begin fails++; $display("[TB] FAIL err_no_write: got %h expected 12345678", rd); end
        xact(1'b0, 3'b010, 32'h00, 32'h0, v, rd, er);
        tests++; if (rd !== 32'h0) begin fails++; $display("[TB] FAIL range_no_alias: got %h expected 00000000", rd); end
    endtask

    task automatic test_misalign();
        logic v, er; logic [31:0] rd;
        xact(1'b1, 3'b010, 32'h52, 32'hCAFEF00D, v, rd, er);
`ifdef DMEM_MISALIGN_TRAP_EN
        tests++; if (er !== 1'b1) begin fails++; $display("[TB] FAIL sw_52: got err=%b expected 1", er); end
        xact(1'b0, 3'b010, 32'h50, 32'h0, v, rd, er);
        tests++; if (rd !== 32'h0) begin fails++; $display("[TB] FAIL lw_50: got %h expected 00000000", rd); end
        xact(1'b0, 3'b001, 32'h11, 32'h0, v, rd, er);
        tests++; if ({er, rd} !== {1'b1, 32'h0}) begin fails++; $display("[TB] FAIL lh_11: got err=%b rdata=%h expected err=1 rdata=00000000", er, rd); end
`else
        tests++; if (er !== 1'b0) begin fails++; $display("[TB] FAIL sw_52: got err=%b expected 0", er); end
        xact(1'b0, 3'b010, 32'h50, 32'h0, v, rd, er);
        tests++; if (rd !== 32'hCAFEF00D) begin fails++; $display("[TB] FAIL lw_50: got %h expected cafef00d", rd); end
        xact(1'b0, 3'b001, 32'h11, 32'h0, v, rd, er);
        tests++; if ({er, rd} !== {1'b0, 32'h00005678}) begin fails++; $display("[TB] FAIL lh_11: got err=%b rdata=%h expected err=0 rdata=00005678", er, rd); end
`endif
    endtask

    task automatic test_reset_midop();
        int cyc; logic early; logic v, er; logic [31:0] rd;
        xact(1'b1, 3'b010, 32'h60, 32'hA5A5A5A5, v, rd, er);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h60; rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        tests++; if ({rsp_valid, rsp_rdata} !== {1'b1, 32'hA5A5A5A5}) begin fails++; $display("[TB] FAIL pre_reset_lw: got v=%b rdata=%h expected v=1 rdata=a5a5a5a5", rsp_valid, rsp_rdata); end
        #2; reset_n = 1'b0; #1;
        tests++; if ({rsp_valid, rsp_rdata, rsp_err, req_ready, init_done} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b0}) begin
            fails++; $display("[TB] FAIL midop_reset: got v=%b rdata=%h err=%b ready=%b done=%b expected all 0", rsp_valid, rsp_rdata, rsp_err, req_ready, init_done);
        end
        @(negedge clk); reset_n = 1'b1;
        wait_init(cyc, early);
        tests++; if (cyc !== 256) begin fails++; $display("[TB] FAIL reinit_cycles: got %0d expected 256", cyc); end
        xact(1'b0, 3'b010, 32'h60, 32'h0, v, rd, er);
        tests++; if ({er, rd} !== {1'b0, 32'h0}) begin fails++; $display("[TB] FAIL cleared_60: got err=%b rdata=%h expected err=0 rdata=00000000", er, rd); end
        xact(1'b0, 3'b010, 32'h10, 32'h0, v, rd, er);
        tests++; if (rd !== 32'h0) begin fails++; $display("[TB] FAIL cleared_10: got %h expected 00000000", rd); end
    endtask

    initial begin
        test_reset();
        test_word_store();
        test_byte_store();
        test_back_to_back();
        test_errors();
        test_misalign();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Parametrised byte-addressed data memory for the RV32 datapath, successor to the single-cycle data memory. Adds a valid/ready request/response handshake with registered one-cycle read latency, full RV32I load/store width decoding (LB/LH/LW/LBU/LHU, SB/SH/SW) with correct byte-lane placement, address-range and funct3 error reporting, and a post-reset memory-clear sweep. Sits between the execute stage (address from ALU, store data from rs2) and the writeback mux.

## Interface
Parameters:
- DEPTH, 256: memory size in 32-bit words; power of two, 4..65536.
- AW, 32: request address width in bits.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted on a cycle with req_valid & req_ready.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 of the load/store.
- req_addr  in  AW  byte address.
- req_wdata  in  32  store data; low byte/half/word used per funct3.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed on a cycle with rsp_valid & rsp_ready.
- rsp_rdata  out  32  load result, extended per funct3; 0 for stores and errors.
- rsp_err  out  1  request rejected (range, funct3, or misalignment when enabled).
- init_done  out  1  memory clear complete; stays 1 until next reset.

## Operation
- States: INIT, IDLE, RESP.
- INIT: word counter 0..DEPTH-1 writes 32'h0 to one word per cycle; req_ready=0. After word DEPTH-1 is written, go to IDLE and set init_done.
- req_ready = (state==IDLE) | (state==RESP & rsp_ready). Single outstanding request; back-to-back acceptance allowed when the current response is consumed in the same cycle.
- On acceptance: evaluate request, capture rsp_rdata/rsp_err, go to RESP with rsp_valid=1. Stores commit to memory at the acceptance edge.
- RESP: hold rsp_valid, rsp_rdata, rsp_err stable until rsp_ready. On rsp_ready without a new acceptance, go to IDLE.
- Word index = req_addr[log2(DEPTH)+1:2]; lane = req_addr[1:0].
- Range error: any req_addr bit above log2(DEPTH)+1 set.
- Loads: 000 LB, 001 LH sign-extend; 100 LBU, 101 LHU zero-extend; 010 LW. LB/LBU take byte at lane; LH/LHU take half at lane[1]*16.
- Stores: 000 SB writes byte lane with req_wdata[7:0]; 001 SH writes half lane[1] with req_wdata[15:0]; 010 SW writes full word. Untouched lanes preserved.
- Illegal funct3 (loads 011/110/111, stores 011..111): rsp_err=1.
- Any error: no memory write, rsp_rdata=0, rsp_err=1.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0; state=INIT, counter=0.
- First request can be accepted DEPTH cycles after reset_n rises.
- Load latency: response valid on the cycle after acceptance.
- Store followed immediately by load to same word returns the stored data (write committed before the load is read).
- reset_n asserted mid-operation: pending response dropped, all outputs to reset values immediately, INIT sweep restarts after release; memory contents fully cleared.
- req_* are ignored while req_ready=0; no side effects.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, produce rsp_err=1, no write, rsp_rdata=0.
- Undefined: misaligned accesses are silently aligned (addr[0] ignored for halves, addr[1:0] ignored for words); rsp_err=0 unless range or funct3 error.

## Test plan
- Reset, DEPTH=256: req_ready stays 0 for 256 cycles, init_done then 1; LW at 0x3FC returns 32'h0, rsp_err=0.
- SW 0x12345678 at 0x10; LB at 0x13 -> 32'h00000012; LH at 0x12 -> 32'h00001234; LW at 0x10 -> 32'h12345678.
- SB 0x80 at 0x21 over word 0; LB at 0x21 -> 32'hFFFFFF80; LBU at 0x21 -> 32'h00000080; LW at 0x20 -> 32'h00008000.
- Back-to-back SH 0xBEEF at 0x40 then LHU at 0x42 with rsp_ready held 0 for 3 cycles: first response held stable, second accepted on the cycle rsp_ready=1, returns 32'h00000000; LHU 0x40 -> 32'h0000BEEF.
- LW at 0x400 (DEPTH=256) -> rsp_err=1, rdata 0; load funct3 011 -> rsp_err=1; SW at 0x402: with DMEM_MISALIGN_TRAP_EN rsp_err=1 and word 0x400>>2 unchanged, without it writes word at 0x400 index... out of range -> rsp_err=1; SW at 0x52 without macro writes word 0x50, rsp_err=0.
- reset_n pulsed low while in RESP: rsp_valid drops same cycle, INIT restarts, previously stored word reads 32'h0 afterwards.
